washing_machine_controller: RTL and testbench

//   Coin-operated washing-machine sequencer: IDLE -> FILLING WATER -> WASHING -> RINSING -> SPINNING -> IDLE.

---
 rtl/washing_machine_controller.sv | 157 +++++++++++++++
 tb/tb_washing_machine_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/washing_machine_controller.sv
// rtl/washing_machine_controller.sv - coin-operated washing machine phase sequencer
module washing_machine_controller #(
  parameter int unsigned FILL_MIN         = 2,
  parameter int unsigned WASH_MIN         = 5,
  parameter int unsigned RINSE_MIN        = 2,
  parameter int unsigned SPIN_MIN         = 1,
  // clk cycles in one minute at the 1 MHz setting; faster settings shift this left
  parameter logic [31:0] CYC_PER_MIN_1MHZ = 32'd60_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] clk_freq,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  output logic       wash_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILLING  = 3'd1,
    WASHING  = 3'd2,
    RINSING  = 3'd3,
    SPINNING = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  freq_q, freq_d;
  logic        dbl_q, dbl_d;
  logic        second_q, second_d;
  logic        paused_q, paused_d;
  logic        done_q, done_d;

  logic [31:0] per_min;
  logic [31:0] phase_min;
  logic [31:0] phase_len;
  logic        phase_last;

  // Length of the current phase in cycles, from the frequency latched at coin acceptance
  always_comb begin
    per_min = CYC_PER_MIN_1MHZ << freq_q;
    case (state)
      FILLING:  phase_min = 32'(FILL_MIN);
      WASHING:  phase_min = 32'(WASH_MIN);
      RINSING:  phase_min = 32'(RINSE_MIN);
      SPINNING: phase_min = 32'(SPIN_MIN);
      default:  phase_min = 32'd0;
    endcase
    phase_len  = phase_min * per_min;
    phase_last = (cnt_q == (phase_len - 32'd1));
  end

  // Next-state and register updates; pause is modelled as IDLE with a frozen spin count
  always_comb begin
    state_d  = state;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    dbl_d    = dbl_q;
    second_d = second_q;
    paused_d = paused_q;
    done_d   = done_q;
    case (state)
      IDLE: begin
        if (paused_q) begin
          if (!timer_pause) begin
            state_d  = SPINNING;
            paused_d = 1'b0;
          end
        end else if (coin_in) begin
          state_d  = FILLING;
          cnt_d    = 32'd0;
          done_d   = 1'b0;
          freq_d   = clk_freq;
          dbl_d    = double_wash;
          second_d = 1'b0;
        end
      end
      FILLING: begin
        if (phase_last) begin
          state_d = WASHING;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WASHING: begin
        if (phase_last) begin
          state_d = RINSING;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RINSING: begin
        if (phase_last) begin
          cnt_d = 32'd0;
          if (dbl_q && !second_q) begin
            state_d  = WASHING;
            second_d = 1'b1;
          end else begin
            state_d = SPINNING;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SPINNING: begin
        // completion takes priority over a simultaneous pause request
        if (phase_last) begin
          state_d  = IDLE;
          cnt_d    = 32'd0;
          done_d   = 1'b1;
          paused_d = 1'b0;
          second_d = 1'b0;
        end else begin
          // the cycle just spent spinning still counts toward spin time
          cnt_d = cnt_q + 32'd1;
          if (timer_pause) begin
            state_d  = IDLE;
            paused_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 32'd0;
        paused_d = 1'b0;
        second_d = 1'b0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt_q    <= 32'd0;
      freq_q   <= 2'd0;
      dbl_q    <= 1'b0;
      second_q <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      dbl_q    <= dbl_d;
      second_q <= second_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign wash_done = done_q;

endmodule

// File: tb/tb_washing_machine_controller.sv
// tb/tb_washing_machine_controller.sv - directed bench for washing_machine_controller
module tb_washing_machine_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] clk_freq;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic       wash_done;

  int checks;
  int failures;

  // 4 cycles per minute at 1 MHz: minute = 4/8/16/32 cycles for clk_freq 00/01/10/11
  washing_machine_controller #(
    .CYC_PER_MIN_1MHZ(32'd4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_freq(clk_freq),
    .coin_in(coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .wash_done(wash_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_sd(input logic [2:0] exp_state, input logic exp_done, input string name);
    logic [2:0] st;
    st = dut.state;
    checks++;
    if (st !== exp_state || wash_done !== exp_done) begin
      failures++;
      $display("FAIL %s: state=%0d wash_done=%0b expected state=%0d wash_done=%0b",
               name, st, wash_done, exp_state, exp_done);
    end
  endtask

  task automatic coin_pulse(input logic [1:0] f, input logic dw);
    clk_freq    = f;
    double_wash = dw;
    coin_in     = 1'b1;
    @(negedge clk);
    coin_in     = 1'b0;
  endtask

  // mode 0: quiet, 1: toggle coin/clk_freq/double_wash, 2: hold timer_pause high
  task automatic measure(input logic [2:0] st, input int exp_len, input int mode, input string name);
    int n;
    logic [2:0] cur;
    n = 0;
    cur = dut.state;
    while (cur == st && n < exp_len + 50) begin
      if (mode == 1) begin
        coin_in     = ~coin_in;
        clk_freq    = clk_freq + 2'd1;
        double_wash = ~double_wash;
      end
      if (mode == 2) timer_pause = 1'b1;
      n++;
      @(negedge clk);
      cur = dut.state;
    end
    if (mode == 1) coin_in = 1'b0;
    if (mode == 2) timer_pause = 1'b0;
    checks++;
    if (n != exp_len) begin
      failures++;
      $display("FAIL %s: cycles_in_state%0d=%0d expected=%0d", name, st, n, exp_len);
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    clk_freq    = 2'b00;
    coin_in     = 1'b0;
    double_wash = 1'b0;
    timer_pause = 1'b0;
    repeat (2) @(negedge clk);
    check_sd(3'd0, 1'b0, "reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_sd(3'd0, 1'b0, "idle_after_reset");
  endtask

  task automatic test_single_cycle;
    coin_pulse(2'b10, 1'b0);
    measure(3'd1, 32, 0, "t1_fill");
    measure(3'd2, 80, 0, "t1_wash");
    measure(3'd3, 32, 0, "t1_rinse");
    measure(3'd4, 16, 0, "t1_spin");
    check_sd(3'd0, 1'b1, "t1_done");
    repeat (3) @(negedge clk);
    check_sd(3'd0, 1'b1, "t1_done_hold");
  endtask

  task automatic test_double_with_pause;
    int bad;
    coin_pulse(2'b11, 1'b1);
    check_sd(3'd1, 1'b0, "t2_done_cleared");
    measure(3'd1, 64, 0, "t2_fill");
    measure(3'd2, 160, 0, "t2_wash1");
    measure(3'd3, 64, 0, "t2_rinse1");
    measure(3'd2, 160, 0, "t2_wash2");
    measure(3'd3, 64, 0, "t2_rinse2");
    check_sd(3'd4, 1'b0, "t3_spin_entry");
    repeat (15) @(negedge clk);
    check_sd(3'd4, 1'b0, "t3_spin_half");
    timer_pause = 1'b1;
    @(negedge clk);
    check_sd(3'd0, 1'b0, "t3_paused");
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      coin_in = (i >= 4 && i < 8);
      if (dut.state !== 3'd0 || wash_done !== 1'b0) bad++;
      @(negedge clk);
    end
    coin_in = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t3_pause_hold: bad_cycles=%0d expected=0", bad);
    end
    check_sd(3'd0, 1'b0, "t3_pause_end");
    timer_pause = 1'b0;
    @(negedge clk);
    measure(3'd4, 16, 0, "t3_spin_resume");
    check_sd(3'd0, 1'b1, "t3_done");
  endtask

  task automatic test_reset_mid_wash;
    coin_pulse(2'b01, 1'b0);
    measure(3'd1, 16, 0, "t4_fill_pre");
    repeat (7) @(negedge clk);
    check_sd(3'd2, 1'b0, "t4_in_wash");
    rst_n = 1'b0;
    #1;
    check_sd(3'd0, 1'b0, "t4_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    coin_pulse(2'b01, 1'b0);
    measure(3'd1, 16, 0, "t4_fill_full");
    measure(3'd2, 40, 0, "t4_wash");
    measure(3'd3, 16, 0, "t4_rinse");
    measure(3'd4, 8, 0, "t4_spin");
    check_sd(3'd0, 1'b1, "t4_done");
  endtask

  task automatic test_rinse_toggles;
    coin_pulse(2'b00, 1'b0);
    measure(3'd1, 8, 0, "t5_fill");
    measure(3'd2, 20, 0, "t5_wash");
    measure(3'd3, 8, 1, "t5_rinse_toggled");
    measure(3'd4, 4, 0, "t5_spin");
    check_sd(3'd0, 1'b1, "t5_done");
  endtask

  task automatic test_pause_in_wash;
    coin_pulse(2'b00, 1'b0);
    measure(3'd1, 8, 0, "t6_fill");
    measure(3'd2, 20, 2, "t6_wash_paused");
    measure(3'd3, 8, 0, "t6_rinse");
    measure(3'd4, 4, 0, "t6_spin");
    check_sd(3'd0, 1'b1, "t6_done");
  endtask

  task automatic test_pause_at_completion;
    coin_pulse(2'b00, 1'b0);
    measure(3'd1, 8, 0, "t7_fill");
    measure(3'd2, 20, 0, "t7_wash");
    measure(3'd3, 8, 0, "t7_rinse");
    repeat (3) @(negedge clk);
    check_sd(3'd4, 1'b0, "t7_spin_last");
    timer_pause = 1'b1;
    @(negedge clk);
    check_sd(3'd0, 1'b1, "t7_completion_wins");
    @(negedge clk);
    timer_pause = 1'b0;
    @(negedge clk);
    check_sd(3'd0, 1'b1, "t7_no_resume");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_cycle();
    test_double_with_pause();
    test_reset_mid_wash();
    test_rinse_toggles();
    test_pause_in_wash();
    test_pause_at_completion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
